// File: rtl/iterative_right_shifter.sv
// rtl/iterative_right_shifter.sv - one-bit-per-clock logical/arithmetic right shifter
// start/busy/done handshake; operand, shamt and fill mode are captured on accept.
module iterative_right_shifter #(
    parameter int WIDTH       = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   i_clock,
    input  logic                   i_reset,
    input  logic                   i_start,
    input  logic [WIDTH-1:0]       i_operand,
    input  logic [SHAMT_WIDTH-1:0] i_shamt,
    input  logic                   i_arithmetic,
    output logic [WIDTH-1:0]       o_result,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [SHAMT_WIDTH-1:0] LP_ONE = SHAMT_WIDTH'(1);

    state_t                 r_state;
    state_t                 w_next;
    logic [WIDTH-1:0]       r_result;
    logic [SHAMT_WIDTH-1:0] r_count;
    logic                   r_arith;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_fill;

    assign w_fill = r_arith & r_result[WIDTH-1];

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = (i_shamt == '0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                // The edge that takes count from 1 to 0 also finishes the shift.
                if (r_count == LP_ONE) begin
                    w_next = S_DONE;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // busy/done are registered from the next state so they line up with r_state.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_result <= '0;
            r_count  <= '0;
            r_arith  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_busy <= (w_next != S_IDLE);
            r_done <= (w_next == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_result <= i_operand;
                        r_count  <= i_shamt;
                        r_arith  <= i_arithmetic;
                    end
                end
                S_SHIFT: begin
                    r_result <= {w_fill, r_result[WIDTH-1:1]};
                    r_count  <= r_count - LP_ONE;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_iterative_right_shifter.sv
// tb/tb_iterative_right_shifter.sv - self-checking bench for iterative_right_shifter
// Directed cases plus randomized operations against an arithmetic reference model.
module tb_iterative_right_shifter;

    localparam int WIDTH = 32;
    localparam int SW    = 5;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] operand;
    logic [SW-1:0]    shamt;
    logic             arithmetic;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    int checks = 0;
    int errors = 0;

    iterative_right_shifter #(.WIDTH(WIDTH), .SHAMT_WIDTH(SW)) dut (
        .i_clock     (clock),
        .i_reset     (reset),
        .i_start     (start),
        .i_operand   (operand),
        .i_shamt     (shamt),
        .i_arithmetic(arithmetic),
        .o_result    (result),
        .o_busy      (busy),
        .o_done      (done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] op,
                                               input int sh, input logic ar);
        logic signed [WIDTH-1:0] s;
        logic [WIDTH-1:0]        r;
        s = op;
        if (ar) r = s >>> sh;
        else    r = op >> sh;
        return r;
    endfunction

    task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                         input logic [WIDTH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait for done (inputs assumed already accepted); returns edges seen.
    task automatic wait_done(input string tag, output int edges);
        edges = 0;
        do begin
            @(negedge clock);
            edges++;
            check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        end while (!done && edges < 64);
    endtask

    task automatic run_op(input string tag, input logic [WIDTH-1:0] op,
                          input int sh, input logic ar);
        int edges;
        logic [WIDTH-1:0] exp;
        exp = model(op, sh, ar);
        check({tag, "_idle_before"}, {31'd0, busy}, 32'd0);
        start      = 1'b1;
        operand    = op;
        shamt      = SW'(sh);
        arithmetic = ar;
        @(posedge clock);
        @(negedge clock);
        start      = 1'b0;
        operand    = $urandom;
        shamt      = SW'($urandom);
        arithmetic = ~ar;
        edges = 1;
        if (!done) begin
            int more;
            check({tag, "_busy_first"}, {31'd0, busy}, 32'd1);
            wait_done(tag, more);
            edges += more;
        end
        check({tag, "_latency"}, WIDTH'(edges), WIDTH'(sh + 1));
        check({tag, "_result"}, result, exp);
        @(negedge clock);
        check({tag, "_done_pulse"}, {30'd0, done, busy}, 32'd0);
        check({tag, "_held"}, result, exp);
    endtask

    initial begin
        int edges;
        int seen_done;
        reset = 1'b1; start = 1'b0; operand = '0; shamt = '0; arithmetic = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        check("reset_result", result, 32'd0);
        check("reset_flags", {30'd0, done, busy}, 32'd0);
        reset = 1'b0;

        // Reset mid-shift discards the request.
        start = 1'b1; operand = 32'hDEAD_BEEF; shamt = 5'd10; arithmetic = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        check("abort_result", result, 32'd0);
        check("abort_flags", {30'd0, done, busy}, 32'd0);
        seen_done = 0;
        repeat (15) begin
            @(negedge clock);
            if (done || busy) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);

        run_op("srl4", 32'hF000_0000, 4, 1'b0);
        check("srl4_const", result, 32'h0F00_0000);
        run_op("sra4", 32'hF000_0000, 4, 1'b1);
        check("sra4_const", result, 32'hFF00_0000);
        run_op("zero", 32'h1234_5678, 0, 1'b0);
        check("zero_const", result, 32'h1234_5678);
        run_op("sra31", 32'h8000_0001, 31, 1'b1);
        check("sra31_const", result, 32'hFFFF_FFFF);
        run_op("srl31", 32'h8000_0001, 31, 1'b0);
        check("srl31_const", result, 32'h0000_0001);

        // start held high; inputs changed during the shift.
        start = 1'b1; operand = 32'h8765_4321; shamt = 5'd3; arithmetic = 1'b1;
        @(posedge clock);
        @(negedge clock);
        operand = 32'h4000_0000; shamt = 5'd2; arithmetic = 1'b1;
        wait_done("held1", edges);
        check("held1_latency", 32'(edges + 1), 32'd4);
        check("held1_result", result, model(32'h8765_4321, 3, 1'b1));
        @(negedge clock);
        check("held_gap_idle", {30'd0, done, busy}, 32'd0);
        check("held_gap_result", result, model(32'h8765_4321, 3, 1'b1));
        @(negedge clock);
        start = 1'b0;
        check("held2_busy", {31'd0, busy}, 32'd1);
        wait_done("held2", edges);
        check("held2_latency", 32'(edges + 1), 32'd3);
        check("held2_result", result, 32'h1000_0000);
        @(negedge clock);

        for (int i = 0; i < 25; i++) begin
            run_op("rand", $urandom, int'($urandom_range(0, WIDTH - 1)),
                   1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
